operand_fetch_stage: RTL and testbench

- Pipeline stage directly downstream of the register file read ports (`data_a`/`data_b`) and upstream of the ALU/execute stage.
- Latches the decoded instruction together with its two source operands into the ID/EX pipeline register.
- Resolves RAW hazards by forwarding from the execute result and from the register-file write port. When forwarding cannot resolve a load-use hazard, it stalls decode.
- Provides valid/ready handshakes on both sides, a synchronous flush, and a saturating stall-cycle counter.

---
 rtl/operand_fetch_stage.sv | 196 +++++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: sits between the register file read ports and execute.
// Latches the decoded instruction and its two resolved source operands into
// the ID/EX pipeline register. RAW hazards are resolved by forwarding from
// the execute result and from the register-file write port. A load-use hazard
// that forwarding cannot cover holds off decode for that cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake (in_ready is combinational)
//   in_addrA/B/D, in_useA/B,
//   in_wr, in_is_load, in_opc  decoded instruction fields
//   rf_data_a/b                register file read data
//   ex_fwd_*, ex_is_load       execute-stage forward source and load flag
//   wb_wrt, wb_addrD, wb_d     register file write port (forward source)
//   flush                      synchronous pipeline kill
//   out_valid / out_ready      downstream handshake
//   out_opA/B, out_addrD,
//   out_wr, out_is_load,
//   out_opc                    ID/EX register contents
//   stall_cnt                  saturating count of hazard-stall cycles
module operand_fetch_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OPC_W  = 7,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // upstream (decode)
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addrA,
  input  logic [ADDR_W-1:0] in_addrB,
  input  logic [ADDR_W-1:0] in_addrD,
  input  logic              in_useA,
  input  logic              in_useB,
  input  logic              in_wr,
  input  logic              in_is_load,
  input  logic [OPC_W-1:0]  in_opc,
  // register file read data
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  // execute-stage forward
  input  logic              ex_fwd_valid,
  input  logic [ADDR_W-1:0] ex_fwd_addr,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              ex_is_load,
  // register file write port
  input  logic              wb_wrt,
  input  logic [ADDR_W-1:0] wb_addrD,
  input  logic [DATA_W-1:0] wb_d,
  // control
  input  logic              flush,
  // downstream (execute)
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_opA,
  output logic [DATA_W-1:0] out_opB,
  output logic [ADDR_W-1:0] out_addrD,
  output logic              out_wr,
  output logic              out_is_load,
  output logic [OPC_W-1:0]  out_opc,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ID/EX payload carried as one bundle so load/hold is a single assignment.
  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] addr_d;
    logic              wr;
    logic              is_load;
    logic [OPC_W-1:0]  opc;
  } idex_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             valid_q, valid_d;
  idex_t            pay_q, pay_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Hazard detection and handshake
  // ---------------------------------------------------------------------------
  logic haz_c;
  logic match_a_c;
  logic match_b_c;
  logic accept_c;

  // Load-use: a used source names the load destination currently in execute.
  always_comb begin
    match_a_c = in_useA & (in_addrA == ex_fwd_addr);
    match_b_c = in_useB & (in_addrB == ex_fwd_addr);
    haz_c     = in_valid & ex_is_load & (match_a_c | match_b_c);
  end

  // in_ready is forced low while reset is asserted.
  always_comb begin
    in_ready = rst_n & ~haz_c & (~valid_q | out_ready);
    accept_c = in_valid & in_ready;
  end

  // ---------------------------------------------------------------------------
  // Operand selection: execute forward > write-port forward > register file.
  // A load in execute has no result yet, so it never forwards.
  // ---------------------------------------------------------------------------
  logic              ex_fwd_ok_c;
  logic [DATA_W-1:0] sel_a_c;
  logic [DATA_W-1:0] sel_b_c;

  always_comb begin
    ex_fwd_ok_c = ex_fwd_valid & ~ex_is_load;
  end

  always_comb begin
    sel_a_c = rf_data_a;
    if (ex_fwd_ok_c && (ex_fwd_addr == in_addrA)) begin
      sel_a_c = ex_fwd_data;
    end else if (wb_wrt && (wb_addrD == in_addrA)) begin
      sel_a_c = wb_d;
    end
  end

  always_comb begin
    sel_b_c = rf_data_b;
    if (ex_fwd_ok_c && (ex_fwd_addr == in_addrB)) begin
      sel_b_c = ex_fwd_data;
    end else if (wb_wrt && (wb_addrD == in_addrB)) begin
      sel_b_c = wb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX register next state
  // Flush kills the slot (and any simultaneous accept) but leaves data fields
  // untouched; a drained slot with no new instruction becomes a bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_c) begin
      valid_d        = 1'b1;
      pay_d.op_a     = sel_a_c;
      pay_d.op_b     = sel_b_c;
      pay_d.addr_d   = in_addrD;
      pay_d.wr       = in_wr;
      pay_d.is_load  = in_is_load;
      pay_d.opc      = in_opc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Stall counter: one count per hazard cycle, saturating, cleared by reset only.
  always_comb begin
    cnt_d = cnt_q;
    if (haz_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid   = valid_q;
    out_opA     = pay_q.op_a;
    out_opB     = pay_q.op_b;
    out_addrD   = pay_q.addr_d;
    out_wr      = pay_q.wr;
    out_is_load = pay_q.is_load;
    out_opc     = pay_q.opc;
    stall_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, basic pass, forward priority,
// load-use stall, backpressure, flush vs accept, async reset, counter saturation.
module tb_operand_fetch_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addrA, in_addrB, in_addrD;
  logic              in_useA, in_useB, in_wr, in_is_load;
  logic [OPC_W-1:0]  in_opc;
  logic [DATA_W-1:0] rf_data_a, rf_data_b;
  logic              ex_fwd_valid;
  logic [ADDR_W-1:0] ex_fwd_addr;
  logic [DATA_W-1:0] ex_fwd_data;
  logic              ex_is_load;
  logic              wb_wrt;
  logic [ADDR_W-1:0] wb_addrD;
  logic [DATA_W-1:0] wb_d;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_opA, out_opB;
  logic [ADDR_W-1:0] out_addrD;
  logic              out_wr, out_is_load;
  logic [OPC_W-1:0]  out_opc;
  logic [CNT_W-1:0]  stall_cnt;

  int total;
  int bad;

  operand_fetch_stage #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addrA(in_addrA), .in_addrB(in_addrB), .in_addrD(in_addrD),
    .in_useA(in_useA), .in_useB(in_useB), .in_wr(in_wr),
    .in_is_load(in_is_load), .in_opc(in_opc),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_addr(ex_fwd_addr),
    .ex_fwd_data(ex_fwd_data), .ex_is_load(ex_is_load),
    .wb_wrt(wb_wrt), .wb_addrD(wb_addrD), .wb_d(wb_d),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opA(out_opA), .out_opB(out_opB), .out_addrD(out_addrD),
    .out_wr(out_wr), .out_is_load(out_is_load), .out_opc(out_opc),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next active edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    ex_fwd_valid = 1'b0; ex_fwd_addr = '0; ex_fwd_data = '0; ex_is_load = 1'b0;
    wb_wrt = 1'b0; wb_addrD = '0; wb_d = '0;
  endtask

  task automatic basic_instr();
    in_valid = 1'b1; in_addrA = 5'd1; in_addrB = 5'd2; in_addrD = 5'd4;
    in_useA = 1'b1; in_useB = 1'b1; in_wr = 1'b1; in_is_load = 1'b0;
    in_opc = 7'h15; rf_data_a = 32'h11; rf_data_b = 32'h22;
    out_ready = 1'b1; flush = 1'b0;
    clear_fwd();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    basic_instr();
    in_valid = 1'b0;

    // Reset state
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_opA", 64'(out_opA), 64'd0);
    chk("rst_opc", 64'(out_opc), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    tick();
    rst_n = 1'b1;

    // Basic pass
    basic_instr();
    #1;
    chk("basic_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_opA", 64'(out_opA), 64'h11);
    chk("basic_opB", 64'(out_opB), 64'h22);
    chk("basic_addrD", 64'(out_addrD), 64'd4);
    chk("basic_wr", 64'(out_wr), 64'd1);
    chk("basic_opc", 64'(out_opc), 64'h15);
    chk("basic_cnt", 64'(stall_cnt), 64'd0);

    // Forward priority: EX > WB > RF
    in_addrA = 5'd5; rf_data_a = 32'hCCCC;
    ex_fwd_valid = 1'b1; ex_fwd_addr = 5'd5; ex_fwd_data = 32'hAAAA;
    wb_wrt = 1'b1; wb_addrD = 5'd5; wb_d = 32'hBBBB;
    tick();
    chk("fwd_ex_opA", 64'(out_opA), 64'hAAAA);
    chk("fwd_ex_opB", 64'(out_opB), 64'h22);
    ex_fwd_valid = 1'b0;
    tick();
    chk("fwd_wb_opA", 64'(out_opA), 64'hBBBB);
    wb_wrt = 1'b0;
    tick();
    chk("fwd_rf_opA", 64'(out_opA), 64'hCCCC);

    // A load in EX never forwards; unused source raises no hazard
    in_useA = 1'b0; ex_fwd_valid = 1'b1; ex_is_load = 1'b1;
    ex_fwd_addr = 5'd5; ex_fwd_data = 32'hAAAA;
    wb_wrt = 1'b1; wb_addrD = 5'd5; wb_d = 32'hBBBB;
    #1;
    chk("unused_ready", 64'(in_ready), 64'd1);
    tick();
    chk("ldfwd_opA", 64'(out_opA), 64'hBBBB);
    chk("unused_cnt", 64'(stall_cnt), 64'd0);

    // Load-use on source B
    clear_fwd();
    in_useA = 1'b1; in_addrA = 5'd1; rf_data_a = 32'h55;
    in_useB = 1'b1; in_addrB = 5'd3; rf_data_b = 32'h99; in_addrD = 5'd7;
    ex_is_load = 1'b1; ex_fwd_addr = 5'd3;
    #1;
    chk("lu_ready", 64'(in_ready), 64'd0);
    tick();
    chk("lu_bubble", 64'(out_valid), 64'd0);
    chk("lu_cnt", 64'(stall_cnt), 64'd1);
    ex_is_load = 1'b0; wb_wrt = 1'b1; wb_addrD = 5'd3; wb_d = 32'h77;
    #1;
    chk("lu_ready2", 64'(in_ready), 64'd1);
    tick();
    chk("lu_valid", 64'(out_valid), 64'd1);
    chk("lu_opA", 64'(out_opA), 64'h55);
    chk("lu_opB", 64'(out_opB), 64'h77);
    chk("lu_addrD", 64'(out_addrD), 64'd7);
    chk("lu_cnt2", 64'(stall_cnt), 64'd1);

    // Backpressure: outputs hold, upstream blocked
    clear_fwd();
    out_ready = 1'b0; rf_data_a = 32'h1234; rf_data_b = 32'h5678;
    in_addrD = 5'd9; in_opc = 7'h2A;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 64'(in_ready), 64'd0);
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_opA", 64'(out_opA), 64'h55);
      chk("bp_opB", 64'(out_opB), 64'h77);
      chk("bp_addrD", 64'(out_addrD), 64'd7);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_new_opA", 64'(out_opA), 64'h1234);
    chk("bp_new_opB", 64'(out_opB), 64'h5678);
    chk("bp_new_opc", 64'(out_opc), 64'h2A);

    // Flush overrides accept; data fields hold
    flush = 1'b1; rf_data_a = 32'hDEAD;
    #1;
    chk("fl_ready", 64'(in_ready), 64'd1);
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_opA_hold", 64'(out_opA), 64'h1234);
    flush = 1'b0;

    // Four more hazard cycles (one with flush) -> count reaches 5
    ex_is_load = 1'b1; ex_fwd_addr = 5'd3; in_addrB = 5'd3;
    tick();
    flush = 1'b1;
    tick();
    chk("flhaz_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    tick();
    tick();
    chk("haz_cnt5", 64'(stall_cnt), 64'd5);
    ex_is_load = 1'b0; rf_data_a = 32'h66;
    tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_opA", 64'(out_opA), 64'h66);
    out_ready = 1'b0; in_valid = 1'b0;

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_cnt", 64'(stall_cnt), 64'd0);
    chk("arst_opA", 64'(out_opA), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    basic_instr();
    tick();
    chk("post_valid", 64'(out_valid), 64'd1);
    chk("post_opA", 64'(out_opA), 64'h11);
    chk("post_opB", 64'(out_opB), 64'h22);
    chk("post_cnt", 64'(stall_cnt), 64'd0);

    // Saturation: 20 hazard cycles on a 4-bit counter stop at 15
    ex_is_load = 1'b1; ex_fwd_addr = 5'd1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 64'(stall_cnt), 64'd15);
    in_valid = 1'b0;
    tick();
    chk("sat_hold", 64'(stall_cnt), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
